// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared FSM encodings and constants for the sequential divider
package seq_divider_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;
    localparam logic [63:0] DIV_ZERO_Q = '1;
endpackage

// File: rtl/seq_divider_sub.sv
// div_sub: a - b as a + ~b + 1 with 4-bit P/G lookahead slices
module div_sub #(parameter int N = 17) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         no_borrow
);
    localparam int G = (N + 3) / 4;
    localparam int M = G * 4;
    logic [M-1:0] p, g, ci;
    logic [G:0] c;
    logic [M-N-1:0] pad_unused;
    assign p = M'(a) ^ ~M'(b);
    assign g = M'(a) & ~M'(b);
    assign c[0] = 1'b1;
    for (genvar k = 0; k < G; k++) begin : grp
        logic [3:0] pp, gg;
        assign pp = p[4*k +: 4];
        assign gg = g[4*k +: 4];
        assign ci[4*k]   = c[k];
        assign ci[4*k+1] = gg[0] | (pp[0] & c[k]);
        assign ci[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[k]);
        assign ci[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c[k]);
        assign c[k+1]    = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c[k]);
    end
    // zero-padded operands make the top carry the true no-borrow flag
    assign {pad_unused, diff} = p ^ ci;
    assign no_borrow = c[G];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per cycle
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    state_t state, nxt;
    logic [CW-1:0] count;
    logic [WIDTH:0] rem, rem_sh, diff, rem_nx;
    logic [WIDTH-1:0] q, d, q_nx;
    logic nb, last, accept, rem_msb_unused;
    assign rem_sh = {rem[WIDTH-1:0], q[WIDTH-1]};
    div_sub #(.N(WIDTH + 1)) u_sub (
        .a(rem_sh),
        .b({1'b0, d}),
        .diff(diff),
        .no_borrow(nb)
    );
    assign rem_nx = nb ? diff : rem_sh;
    assign q_nx = {q[WIDTH-2:0], nb};
    assign rem_msb_unused = rem[WIDTH];
    assign last = count == CW'(WIDTH - 1);
    assign accept = start && state != RUN;
    assign busy = state == RUN;
    assign done = state == DONE;
    always_comb begin
        nxt = state;
        nxt = state == RUN ? (last ? DONE : RUN) : !start ? IDLE : divisor == '0 ? DONE : RUN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            q           <= '0;
            d           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                count       <= '0;
                rem         <= '0;
                q           <= dividend;
                d           <= divisor;
                div_by_zero <= 1'b0;
                if (divisor == '0) begin
                    quotient    <= DIV_ZERO_Q[WIDTH-1:0];
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == RUN) begin
                rem   <= rem_nx;
                q     <= q_nx;
                count <= count + 1'b1;
                if (last) begin
                    quotient  <= q_nx;
                    remainder <= rem_nx[WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table, corner-sequence and random checks with a result scoreboard
module tb_seq_divider;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } exp_t;

    logic clk = 0, rst = 1, start = 0;
    logic [15:0] dividend = 0, divisor = 0;
    logic busy, done, div_by_zero;
    logic [15:0] quotient, remainder;
    int total = 0, bad = 0;
    exp_t sb[$];
    exp_t e;
    exp_t tbl[7];

    seq_divider #(.WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, want);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t m;
        m.a = a;
        m.b = b;
        m.z = b == 0;
        m.q = b == 0 ? 16'hFFFF : a / b;
        m.r = b == 0 ? a : a % b;
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.z);
                if (e.b != 0) begin
                    chk("rem_lt_div", remainder < e.b, 1);
                    chk("identity", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                end
            end
        end
    end

    task automatic launch(input exp_t x, input bit push);
        @(negedge clk);
        dividend = x.a;
        divisor = x.b;
        start = 1;
        if (push) sb.push_back(x);
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        do begin
            @(negedge clk);
            lat++;
            start = 0;
        end while (!done && lat < 40);
        if (!done) chk("timeout", 0, 1);
    endtask

    initial begin
        int lat;
        exp_t x;
        tbl[0] = '{a: 16'd100,   b: 16'd7,      q: 16'd14,   r: 16'd2, z: 1'b0};
        tbl[1] = '{a: 16'hFFFF,  b: 16'd1,      q: 16'hFFFF, r: 16'd0, z: 1'b0};
        tbl[2] = '{a: 16'd3,     b: 16'h8000,   q: 16'd0,    r: 16'd3, z: 1'b0};
        tbl[3] = '{a: 16'hFFFF,  b: 16'hFFFF,   q: 16'd1,    r: 16'd0, z: 1'b0};
        tbl[4] = '{a: 16'd5,     b: 16'd0,      q: 16'hFFFF, r: 16'd5, z: 1'b1};
        tbl[5] = '{a: 16'd0,     b: 16'd5,      q: 16'd0,    r: 16'd0, z: 1'b0};
        tbl[6] = '{a: 16'd1000,  b: 16'd1000,   q: 16'd1,    r: 16'd0, z: 1'b0};
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 0;

        for (int i = 0; i < 7; i++) begin
            launch(tbl[i], 1);
            wait_done(0, lat);
            chk("latency", lat, tbl[i].b == 0 ? 1 : 17);
        end

        launch(model(16'd5, 16'd0), 1);
        wait_done(0, lat);
        chk("zero_latency", lat, 1);
        launch(model(16'd9, 16'd3), 1);
        @(negedge clk);
        start = 0;
        chk("dbz_cleared", div_by_zero, 0);
        chk("busy_after_start", busy, 1);
        wait_done(1, lat);
        chk("latency_after_zero", lat, 17);

        launch(model(16'd200, 16'd7), 1);
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        dividend = 16'd1000;
        divisor = 16'd3;
        start = 1;
        wait_done(3, lat);
        chk("ignore_latency", lat, 17);

        launch(model(16'd1234, 16'd5), 0);
        @(negedge clk);
        start = 0;
        repeat (8) @(negedge clk);
        chk("busy_before_rst", busy, 1);
        rst = 1;
        @(negedge clk);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        chk("midrun_rst_q", quotient, 0);
        chk("midrun_rst_r", remainder, 0);
        chk("midrun_rst_dbz", div_by_zero, 0);
        rst = 0;
        launch(model(16'd9, 16'd3), 1);
        wait_done(0, lat);
        chk("post_rst_latency", lat, 17);

        launch(model(16'd50, 16'd6), 1);
        wait_done(0, lat);
        chk("b2b_first_latency", lat, 17);
        chk("b2b_first_busy_low", busy, 0);
        dividend = 16'd81;
        divisor = 16'd9;
        start = 1;
        sb.push_back(model(16'd81, 16'd9));
        @(negedge clk);
        start = 0;
        chk("b2b_busy_no_gap", busy, 1);
        wait_done(1, lat);
        chk("b2b_second_latency", lat, 17);

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = $urandom_range(0, 99) < 5 ? 16'd0 :
                 $urandom_range(0, 1) == 1 ? 16'($urandom_range(1, 255)) : 16'($urandom);
            x = model(ra, rb);
            launch(x, 1);
            wait_done(0, lat);
            chk("rand_latency", lat, rb == 0 ? 1 : 17);
        end

        @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
